// File: rtl/smi_arbiter_if.sv
// Requester-side and smi-side signal bundle of the smi arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface smi_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_write_n;
  logic [5*NUM_REQ-1:0]  req_phy_addr;
  logic [5*NUM_REQ-1:0]  req_reg_addr;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  err;
  logic [15:0]           rdata;
  logic                  arb_busy;
  logic                  smi_start;
  logic                  smi_write_n;
  logic [4:0]            smi_phy_addr;
  logic [4:0]            smi_reg_addr;
  logic [15:0]           smi_write_data;
  logic                  smi_busy;
  logic [15:0]           smi_data_read;

  modport slave (
    input  req, req_write_n, req_phy_addr, req_reg_addr, req_wdata,
    input  smi_busy, smi_data_read,
    output grant, done, err, rdata, arb_busy,
    output smi_start, smi_write_n, smi_phy_addr, smi_reg_addr, smi_write_data
  );

  modport master (
    output req, req_write_n, req_phy_addr, req_reg_addr, req_wdata,
    output smi_busy, smi_data_read,
    input  grant, done, err, rdata, arb_busy,
    input  smi_start, smi_write_n, smi_phy_addr, smi_reg_addr, smi_write_data
  );
endinterface

// File: rtl/smi_arbiter.sv
// Round-robin arbiter sharing one smi MDIO master between NUM_REQ requesters.
// Latches the winner's command, runs the start/busy handshake, times out a dead start.
module smi_arbiter #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned START_TIMEOUT = 1024
) (
  input  logic         clk100Mhz,
  input  logic         rst_n,
  smi_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(START_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic [15:0]        r_rdata, w_rdata_nxt;
  logic               r_arb_busy, w_arb_busy_nxt;
  logic               r_smi_start, w_smi_start_nxt;
  logic               r_smi_write_n, w_smi_write_n_nxt;
  logic [4:0]         r_smi_phy_addr, w_smi_phy_addr_nxt;
  logic [4:0]         r_smi_reg_addr, w_smi_reg_addr_nxt;
  logic [15:0]        r_smi_write_data, w_smi_write_data_nxt;

  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic               w_sel_write_n;
  logic [4:0]         w_sel_phy_addr;
  logic [4:0]         w_sel_reg_addr;
  logic [15:0]        w_sel_wdata;

  // First requester at or after r_ptr+1 (modulo NUM_REQ) wins
  always_comb begin : rr_search
    int unsigned idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(r_ptr) + k) % NUM_REQ;
      if (!w_found && bus.req[PTR_W'(idx)]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(idx);
      end
    end
  end

  // Command fields of the winning requester
  always_comb begin : cmd_mux
    w_sel_write_n  = 1'b0;
    w_sel_phy_addr = '0;
    w_sel_reg_addr = '0;
    w_sel_wdata    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_winner == PTR_W'(i)) begin
        w_sel_write_n  = bus.req_write_n[i];
        w_sel_phy_addr = bus.req_phy_addr[5*i +: 5];
        w_sel_reg_addr = bus.req_reg_addr[5*i +: 5];
        w_sel_wdata    = bus.req_wdata[16*i +: 16];
      end
    end
  end

  always_comb begin : fsm_next
    w_state_nxt          = r_state;
    w_ptr_nxt            = r_ptr;
    w_timer_nxt          = r_timer;
    w_grant_nxt          = r_grant;
    w_done_nxt           = '0;
    w_err_nxt            = 1'b0;
    w_rdata_nxt          = r_rdata;
    w_smi_start_nxt      = r_smi_start;
    w_smi_write_n_nxt    = r_smi_write_n;
    w_smi_phy_addr_nxt   = r_smi_phy_addr;
    w_smi_reg_addr_nxt   = r_smi_reg_addr;
    w_smi_write_data_nxt = r_smi_write_data;

    case (r_state)
      S_IDLE: begin
        // Foreign smi activity blocks new grants
        if (w_found && !bus.smi_busy) begin
          w_state_nxt          = S_ISSUE;
          w_ptr_nxt            = w_winner;
          w_grant_nxt          = NUM_REQ'(1) << w_winner;
          w_smi_start_nxt      = 1'b1;
          w_timer_nxt          = '0;
          w_smi_write_n_nxt    = w_sel_write_n;
          w_smi_phy_addr_nxt   = w_sel_phy_addr;
          w_smi_reg_addr_nxt   = w_sel_reg_addr;
          w_smi_write_data_nxt = w_sel_wdata;
        end
      end
      S_ISSUE: begin
        if (bus.smi_busy) begin
          w_smi_start_nxt = 1'b0;
          w_state_nxt     = S_WAIT_DONE;
        end else if (r_timer == TMR_LAST) begin
          w_smi_start_nxt = 1'b0;
          w_done_nxt      = NUM_REQ'(1) << r_ptr;
          w_err_nxt       = 1'b1;
          w_grant_nxt     = '0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus.smi_busy) begin
          if (!r_smi_write_n) begin
            w_rdata_nxt = bus.smi_data_read;
          end
          w_done_nxt  = NUM_REQ'(1) << r_ptr;
          w_grant_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_arb_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk100Mhz or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_ptr            <= PTR_RST;
      r_timer          <= '0;
      r_grant          <= '0;
      r_done           <= '0;
      r_err            <= 1'b0;
      r_rdata          <= '0;
      r_arb_busy       <= 1'b0;
      r_smi_start      <= 1'b0;
      r_smi_write_n    <= 1'b0;
      r_smi_phy_addr   <= '0;
      r_smi_reg_addr   <= '0;
      r_smi_write_data <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_ptr            <= w_ptr_nxt;
      r_timer          <= w_timer_nxt;
      r_grant          <= w_grant_nxt;
      r_done           <= w_done_nxt;
      r_err            <= w_err_nxt;
      r_rdata          <= w_rdata_nxt;
      r_arb_busy       <= w_arb_busy_nxt;
      r_smi_start      <= w_smi_start_nxt;
      r_smi_write_n    <= w_smi_write_n_nxt;
      r_smi_phy_addr   <= w_smi_phy_addr_nxt;
      r_smi_reg_addr   <= w_smi_reg_addr_nxt;
      r_smi_write_data <= w_smi_write_data_nxt;
    end
  end

  assign bus.grant          = r_grant;
  assign bus.done           = r_done;
  assign bus.err            = r_err;
  assign bus.rdata          = r_rdata;
  assign bus.arb_busy       = r_arb_busy;
  assign bus.smi_start      = r_smi_start;
  assign bus.smi_write_n    = r_smi_write_n;
  assign bus.smi_phy_addr   = r_smi_phy_addr;
  assign bus.smi_reg_addr   = r_smi_reg_addr;
  assign bus.smi_write_data = r_smi_write_data;

endmodule

// File: tb/tb_smi_arbiter.sv
// Directed bench for smi_arbiter: behavioural smi responder, requester drop-on-done,
// and a completion scoreboard checked whenever a done pulse appears.
module tb_smi_arbiter;

  localparam int unsigned NUM_REQ       = 3;
  localparam int unsigned START_TIMEOUT = 16;

  typedef struct {
    int          idx;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic clk100Mhz;
  logic rst_n;

  smi_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  smi_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk100Mhz(clk100Mhz),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  int          pend[NUM_REQ];
  logic        model_en = 1'b1;
  int          busy_delay = 3;
  int          busy_len = 4;
  logic [15:0] model_rdata = 16'h0000;
  logic        b2b_mode = 1'b0;
  logic        b2b_seen = 1'b0;

  initial begin
    clk100Mhz = 1'b0;
    forever #5 clk100Mhz = ~clk100Mhz;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100Mhz);
    #2;
  endtask

  task automatic set_cmd(input int i, input logic wn, input logic [4:0] phy,
                         input logic [4:0] reg_a, input logic [15:0] wd);
    bus.req_write_n[i]           = wn;
    bus.req_phy_addr[5*i +: 5]   = phy;
    bus.req_reg_addr[5*i +: 5]   = reg_a;
    bus.req_wdata[16*i +: 16]    = wd;
  endtask

  task automatic push_exp(input int idx, input logic err, input logic [15:0] rd);
    exp_t e;
    e.idx   = idx;
    e.err   = err;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic start_req(input int i, input int n);
    pend[i]    = n;
    bus.req[i] = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.arb_busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0 && bus.arb_busy === 1'b0) else begin
      errors++;
      $error("FAIL %s_drain: observed pending=%0d arb_busy=%b expected pending=0 arb_busy=0",
             tag, exp_q.size(), bus.arb_busy);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_grant"},    32'(bus.grant),          32'h0);
    chk({tag, "_done"},     32'(bus.done),           32'h0);
    chk({tag, "_err"},      32'(bus.err),            32'h0);
    chk({tag, "_rdata"},    32'(bus.rdata),          32'h0);
    chk({tag, "_arb_busy"}, 32'(bus.arb_busy),       32'h0);
    chk({tag, "_start"},    32'(bus.smi_start),      32'h0);
    chk({tag, "_write_n"},  32'(bus.smi_write_n),    32'h0);
    chk({tag, "_phy"},      32'(bus.smi_phy_addr),   32'h0);
    chk({tag, "_reg"},      32'(bus.smi_reg_addr),   32'h0);
    chk({tag, "_wdata"},    32'(bus.smi_write_data), 32'h0);
  endtask

  // smi engine model: busy rises busy_delay cycles after start, holds busy_len cycles
  initial begin : smi_model
    int m_phase;
    int m_cnt;
    m_phase = 0;
    m_cnt   = 0;
    bus.smi_busy      = 1'b0;
    bus.smi_data_read = 16'h0000;
    forever begin
      @(posedge clk100Mhz or negedge rst_n);
      #1;
      if (!rst_n) begin
        m_phase      = 0;
        m_cnt        = 0;
        bus.smi_busy = 1'b0;
      end else begin
        case (m_phase)
          0: if (model_en && bus.smi_start === 1'b1) begin
            m_phase = 1;
            m_cnt   = 1;
          end
          1: begin
            m_cnt++;
            if (m_cnt >= busy_delay) begin
              bus.smi_busy      = 1'b1;
              bus.smi_data_read = model_rdata;
              m_phase = 2;
              m_cnt   = 0;
            end
          end
          default: begin
            m_cnt++;
            if (m_cnt >= busy_len) begin
              bus.smi_busy = 1'b0;
              m_phase      = 0;
            end
          end
        endcase
      end
    end
  end

  // Scoreboard consumer and requester model (drops req once its commands are done)
  initial begin : monitor
    logic [NUM_REQ-1:0] prev_grant;
    logic [NUM_REQ-1:0] exp_vec;
    exp_t               e;
    int                 cyc;
    int                 done_cyc;
    prev_grant = '0;
    cyc        = 0;
    done_cyc   = 0;
    forever begin
      @(posedge clk100Mhz);
      #1;
      cyc++;
      if (rst_n !== 1'b1) begin
        prev_grant = '0;
      end else begin
        checks++;
        assert ($onehot0(bus.grant)) else begin
          errors++;
          $error("FAIL grant_onehot: observed=%b expected at most one bit set", bus.grant);
        end
        if (bus.grant != '0 && prev_grant == '0) begin
          exp_vec = (exp_q.size() > 0) ? (NUM_REQ'(1) << exp_q[0].idx) : '0;
          chk("grant_order", 32'(bus.grant), 32'(exp_vec));
          if (b2b_mode && b2b_seen) chk("b2b_gap", 32'(cyc - done_cyc), 32'd1);
        end
        if (bus.done != '0) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
          end else begin
            e.idx   = -1;
            e.err   = 1'b0;
            e.rdata = bus.rdata ^ 16'hFFFF;
          end
          exp_vec = (e.idx >= 0) ? (NUM_REQ'(1) << e.idx) : '0;
          chk("done_owner", 32'(bus.done),  32'(exp_vec));
          chk("done_err",   32'(bus.err),   32'(e.err));
          chk("done_rdata", 32'(bus.rdata), 32'(e.rdata));
          chk("done_grant_clr", 32'({bus.grant, bus.arb_busy}), 32'h0);
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (bus.done[i] && pend[i] > 0) begin
              pend[i]--;
              if (pend[i] == 0) bus.req[i] = 1'b0;
            end
          end
          if (b2b_mode) b2b_seen = 1'b1;
          done_cyc = cyc;
        end else begin
          chk("err_without_done", 32'(bus.err), 32'h0);
        end
        prev_grant = bus.grant;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    rst_n            = 1'b1;
    bus.req          = '0;
    bus.req_write_n  = '0;
    bus.req_phy_addr = '0;
    bus.req_reg_addr = '0;
    bus.req_wdata    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) pend[i] = 0;
    #1 rst_n = 1'b0;
    #1;
    check_reset("por");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // All-request fairness: order 0,1,2,0 starting from the reset pointer
    model_en = 1'b1; busy_delay = 2; busy_len = 2; model_rdata = 16'h1234;
    set_cmd(0, 1'b1, 5'h10, 5'd1, 16'h0A0A);
    set_cmd(1, 1'b1, 5'h11, 5'd1, 16'h1B1B);
    set_cmd(2, 1'b0, 5'd7,  5'd8, 16'h0000);
    push_exp(0, 1'b0, 16'h0000);
    push_exp(1, 1'b0, 16'h0000);
    push_exp(2, 1'b0, 16'h1234);
    push_exp(0, 1'b0, 16'h1234);
    pend[0] = 2; pend[1] = 1; pend[2] = 1;
    bus.req = 3'b111;
    wait_drain("fair", 200);

    // Single read from requester 0
    busy_delay = 3; busy_len = 4; model_rdata = 16'h7949;
    set_cmd(0, 1'b0, 5'd1, 5'd2, 16'h0000);
    push_exp(0, 1'b0, 16'h7949);
    start_req(0, 1);
    tick();
    chk("rd_grant",    32'(bus.grant),        32'b001);
    chk("rd_start",    32'(bus.smi_start),    32'h1);
    chk("rd_arb_busy", 32'(bus.arb_busy),     32'h1);
    chk("rd_write_n",  32'(bus.smi_write_n),  32'h0);
    chk("rd_phy",      32'(bus.smi_phy_addr), 32'd1);
    chk("rd_reg",      32'(bus.smi_reg_addr), 32'd2);
    n = 0;
    while (bus.smi_busy !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rd_start_until_busy", 32'({bus.smi_busy, bus.smi_start}), 32'b11);
    tick();
    chk("rd_start_drop", 32'(bus.smi_start), 32'h0);
    wait_drain("read", 50);

    // Back-to-back alternation between requesters 1 and 2
    busy_delay = 2; busy_len = 2;
    set_cmd(1, 1'b1, 5'd3, 5'd9,  16'h5A5A);
    set_cmd(2, 1'b1, 5'd4, 5'd10, 16'hA5A5);
    push_exp(1, 1'b0, 16'h7949);
    push_exp(2, 1'b0, 16'h7949);
    push_exp(1, 1'b0, 16'h7949);
    push_exp(2, 1'b0, 16'h7949);
    b2b_seen = 1'b0;
    b2b_mode = 1'b1;
    pend[1] = 2; pend[2] = 2;
    bus.req = 3'b110;
    wait_drain("b2b", 200);
    b2b_mode = 1'b0;

    // Write path from requester 1; rdata must hold
    set_cmd(1, 1'b1, 5'd3, 5'd4, 16'h1000);
    push_exp(1, 1'b0, 16'h7949);
    start_req(1, 1);
    tick();
    chk("wr_grant",   32'(bus.grant),          32'b010);
    chk("wr_write_n", 32'(bus.smi_write_n),    32'h1);
    chk("wr_wdata",   32'(bus.smi_write_data), 32'h1000);
    chk("wr_phy_reg", 32'({bus.smi_phy_addr, bus.smi_reg_addr}), 32'({5'd3, 5'd4}));
    wait_drain("write", 50);

    // Start timeout: smi engine never raises busy
    model_en = 1'b0;
    set_cmd(2, 1'b0, 5'd6, 5'd7, 16'h0000);
    push_exp(2, 1'b1, 16'h7949);
    start_req(2, 1);
    tick();
    chk("to_grant", 32'(bus.grant),     32'b100);
    chk("to_start", 32'(bus.smi_start), 32'h1);
    n = 0;
    while (bus.done[2] !== 1'b1 && n < int'(START_TIMEOUT) + 10) begin tick(); n++; end
    chk("to_latency", 32'(n), 32'(START_TIMEOUT));
    chk("to_err",     32'(bus.err),       32'h1);
    chk("to_start_0", 32'(bus.smi_start), 32'h0);
    wait_drain("timeout", 20);
    model_en = 1'b1;

    // Reset in WAIT_DONE, then requester 0 wins first again
    busy_delay = 2; busy_len = 30; model_rdata = 16'hDEAD;
    set_cmd(0, 1'b0, 5'd2, 5'd3, 16'h0000);
    push_exp(0, 1'b0, 16'hDEAD);
    start_req(0, 1);
    tick();
    n = 0;
    while (bus.smi_busy !== 1'b1 && n < 20) begin tick(); n++; end
    repeat (3) tick();
    chk("rst_in_wait_done", 32'({bus.arb_busy, bus.smi_start}), 32'b10);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(NUM_REQ); i++) pend[i] = 0;
    bus.req = '0;
    #1;
    check_reset("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    busy_len = 3; model_rdata = 16'hBEEF;
    set_cmd(0, 1'b0, 5'd5, 5'd6, 16'h0000);
    set_cmd(1, 1'b1, 5'd9, 5'd10, 16'h2222);
    push_exp(0, 1'b0, 16'hBEEF);
    push_exp(1, 1'b0, 16'hBEEF);
    pend[0] = 1; pend[1] = 1;
    bus.req = 3'b011;
    tick();
    chk("post_rst_grant", 32'(bus.grant),        32'b001);
    chk("post_rst_phy",   32'(bus.smi_phy_addr), 32'd5);
    wait_drain("post_rst", 100);
    chk("final_rdata", 32'(bus.rdata), 32'hBEEF);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smi_arbiter.md
Name: smi_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single smi MDIO master between NUM_REQ independent requesters, e.g. PHY init, link-status poller and debug register access.
- Sits between the requesters and the smi instance, in the clk100Mhz domain.
- Latches the granted requester's command, drives the smi start/busy handshake, returns read data, and reports a timeout error if the smi engine never accepts a start.

Parameters:
- NUM_REQ, 3: number of requesters, 2..8.
- START_TIMEOUT, 1024: clk100Mhz cycles allowed in ISSUE for smi_busy to rise before the command is aborted.

Ports:
- clk100Mhz  in  1  system clock.
- rst_n  in  1  reset.
- req  in  NUM_REQ  per-requester request level; held until matching done pulse.
- req_write_n  in  NUM_REQ  per-requester 1=write, 0=read.
- req_phy_addr  in  5*NUM_REQ  packed PHY addresses; slice i belongs to requester i.
- req_reg_addr  in  5*NUM_REQ  packed register addresses.
- req_wdata  in  16*NUM_REQ  packed write data.
- grant  out  NUM_REQ  one-hot, high from grant until done.
- done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- err  out  1  one-cycle pulse coincident with done when the command timed out.
- rdata  out  16  read data of the last successful read.
- arb_busy  out  1  high whenever state != IDLE.
- smi_start  out  1  to smi start.
- smi_write_n  out  1  to smi write_n.
- smi_phy_addr  out  5  to smi phy_addr.
- smi_reg_addr  out  5  to smi reg_addr.
- smi_write_data  out  16  to smi write_data.
- smi_busy  in  1  from smi busy.
- smi_data_read  in  16  from smi data_read.

Behaviour:
- Interface decision: reset rst_n, asynchronous, active-low; clock clk100Mhz. All outputs are registered.
- Reset values:
  - grant, done, err, smi_start, smi_write_n, arb_busy = 0.
  - smi_phy_addr, smi_reg_addr, smi_write_data, rdata = 0.
  - state = IDLE, timer = 0.
  - last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- Timer width is clog2(START_TIMEOUT+1).
- Round-robin selection: search starts at pointer+1 and wraps modulo NUM_REQ. The first index with req high wins. The pointer updates to the winner at grant.
- State IDLE:
  - Condition: |req && !smi_busy.
  - On the next edge: grant[winner]=1, arb_busy=1, smi_start=1, timer=0, go ISSUE.
  - The winner's write_n, phy_addr, reg_addr and wdata are latched into the smi_* outputs at that edge.
  - If smi_busy is high in IDLE (foreign activity), no grant is issued.
- State ISSUE:
  - smi_busy=1: smi_start<=0, go WAIT_DONE.
  - Else if timer==START_TIMEOUT-1: smi_start<=0, done[owner]<=1, err<=1, grant<=0, go IDLE.
  - Else timer increments.
- State WAIT_DONE:
  - Exit condition is smi_busy=0.
  - On exit: if smi_write_n==0, rdata<=smi_data_read.
  - done[owner]<=1, grant<=0, arb_busy<=0, go IDLE.
  - No timeout in this state; the smi engine always terminates a frame.
- Latency:
  - req to grant/smi_start: 1 cycle.
  - smi_busy falling to done: 1 cycle.
- Back-to-back: the IDLE cycle following done may already grant the next requester.
- Pulses: done and err are high for exactly one cycle.
- Requester rules:
  - Command fields must be stable while req is high; they are sampled only at grant.
  - req must drop in the cycle after done unless a further command is wanted. A still-high req is re-arbitrated with the lowest priority.
  - Dropping req during a transaction does not abort it; done is still pulsed.
- rdata is unchanged by writes and timed-out reads.
- Simultaneous requests: exactly one grant; the other requests stay pending with no loss.
- Reset mid-operation: immediate return to reset values. smi_start drops asynchronously; the smi engine is reset by the same rst_n.

Test Plan:
- Read, single requester: req[0]=1, read, phy 1, reg 2; smi model asserts busy 3 cycles after start then returns 16'h7949 -> grant=001, smi_start high until busy, done[0] pulse, rdata=16'h7949, err=0.
- All-request fairness: req=111 held, each completion normal -> grant order 0,1,2,0; each done one cycle; exactly one grant bit at a time.
- Back-to-back alternation: req[1] and req[2] continuously high -> grants alternate 1,2,1,2; no IDLE gap beyond one cycle after each done.
- Timeout: smi_busy tied 0 -> after START_TIMEOUT cycles in ISSUE, done[owner]=1 and err=1 same cycle, smi_start=0, rdata unchanged.
- Write path: req[1], write_n=1, wdata=16'h1000 -> smi_write_data=16'h1000, smi_write_n=1, done[1] pulse, rdata keeps its previous value.
- Reset mid-WAIT_DONE: rst_n low -> all outputs at reset values immediately; after release with req=011 -> requester 0 is granted first.
